pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
- REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; no other clock or reset.
- REQ-002 Port `clk`: input, 1 bit, rising-edge clock.
- REQ-003 Port `rst_n`: input, 1 bit, asynchronous active-low reset.
- REQ-004 Port DEC_IR: input, 32 bits, instruction in decode.
- REQ-005 Port EXE_IR: input, 32 bits, instruction in execute.
- REQ-006 Port BR_TAKEN: input, 1 bit, decode-stage control transfer taken (branch taken, JAL, JALR).
- REQ-007 Port MEM_REQ: input, 1 bit, memory stage holds a LOAD or STORE.
- REQ-008 Port MEM_READY: input, 1 bit, data memory done this cycle.
- REQ-009 Port INTR: input, 1 bit, level interrupt request.
- REQ-010 Port INT_EN: input, 1 bit, interrupt enable.
- REQ-011 Port PC_WE: output, 1 bit, PC write enable.
- REQ-012 Port IF_DEC_WE: output, 1 bit, IF/DEC register write enable.
- REQ-013 Port DEC_EXE_WE: output, 1 bit, DEC/EXE register write enable.
- REQ-014 Port EXE_MEM_WE: output, 1 bit, EXE/MEM register write enable.
- REQ-015 Port MEM_WB_WE: output, 1 bit, MEM/WB register write enable.
- REQ-016 Port IF_DEC_FLUSH: output, 1 bit, load NOP into IF/DEC.
- REQ-017 Port DEC_EXE_FLUSH: output, 1 bit, load NOP (bubble) into DEC/EXE.
- REQ-018 Port MEM_WB_FLUSH: output, 1 bit, load NOP into MEM/WB.
- REQ-019 Port INT_TAKEN: output, 1 bit, one-cycle interrupt accept pulse.
- REQ-020 Port STATE: output, 2 bits, current FSM state.
- REQ-021 Port STALL_CNT: output, 16 bits, saturating count of stall cycles.

Function
- REQ-022 FSM states SHALL be RUN=0, MEM_WAIT=1, FLUSH=2, INTR=3.
- REQ-023 Outputs SHALL be combinational from state and inputs: all WE=1, all FLUSH=0, INT_TAKEN=0 unless overridden below.
- REQ-024 Load-use is defined as: EXE_IR[6:0]=LOAD, rd!=0, and rd matches a DEC_IR source register in use.
- REQ-025 rs1 is in use for all opcodes except LUI/AUIPC/JAL; rs2 only for OP/STORE/BRANCH.
- REQ-026 RUN priority SHALL be: memory wait > load-use > BR_TAKEN > interrupt.
- REQ-027 RUN, MEM_REQ=1 and MEM_READY=0: all WE=0, MEM_WB_FLUSH=1; next state MEM_WAIT.
- REQ-028 RUN, load-use: PC_WE=0, IF_DEC_WE=0, DEC_EXE_FLUSH=1 for exactly one cycle; stay in RUN; BR_TAKEN ignored that cycle.
- REQ-029 RUN, BR_TAKEN: IF_DEC_FLUSH=1; next state FLUSH.
- REQ-030 RUN, INTR=1 and INT_EN=1 with no higher event: next state INTR.
- REQ-031 MEM_WAIT: same outputs as REQ-027 while MEM_READY=0; MEM_READY=1 releases all WE that cycle; next state RUN.
- REQ-032 FLUSH: IF_DEC_FLUSH=1 (second cycle of fetch squash); next state RUN.
- REQ-033 FLUSH with MEM_REQ=1 and MEM_READY=0: MEM_WAIT outputs with IF_DEC_FLUSH held; go to MEM_WAIT, then FLUSH again after ready.
- REQ-034 INTR: INT_TAKEN=1, IF_DEC_FLUSH=1, DEC_EXE_FLUSH=1 for one cycle; next state FLUSH.
- REQ-035 STALL_CNT SHALL increment by 1 on each cycle where PC_WE=0, and saturate at 16'hFFFF (no wrap).

Reset
- REQ-036 rst_n=0 SHALL asynchronously force STATE=RUN and STALL_CNT=0, aborting any stall, flush, or interrupt in progress.
- REQ-037 During reset, PC_WE and all other WE outputs SHALL be 0, all FLUSH outputs 1, and INT_TAKEN 0.
- REQ-038 The first rising edge after reset deassertion SHALL evaluate RUN normally.

Structure
- REQ-039 opcode_t and the state enum SHALL live in the shared package otter_pkg, replacing the per-module opcode enums.
- REQ-040 Load-use detection SHALL be a combinational sub-module load_use_detect (inputs DEC_IR and EXE_IR; output 1 bit).

Verification
- REQ-041 EXE_IR=lw x5,0(x1); DEC_IR=add x6,x5,x2 -> one cycle with PC_WE=0, DEC_EXE_FLUSH=1; STALL_CNT=1.
- REQ-042 EXE_IR=lw x0,...; DEC_IR=add x6,x0,x0 -> no stall.
- REQ-043 BR_TAKEN pulse in RUN -> IF_DEC_FLUSH=1 for 2 consecutive cycles; STATE sequence RUN, FLUSH, RUN.
- REQ-044 MEM_REQ=1 with MEM_READY low for 3 cycles -> all WE=0 for 3 cycles, then release; STALL_CNT=3.
- REQ-045 INTR=1 and INT_EN=1 with no hazard -> exactly one INT_TAKEN pulse, then FLUSH; INT_EN=0 -> no pulse.
- REQ-046 Force STALL_CNT near 16'hFFFF and apply further stalls -> it holds at FFFF; asserting rst_n=0 mid-MEM_WAIT -> immediate RUN and count 0.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared OTTER pipeline types: RV32I major opcodes, hazard-controller FSM states,
// and helpers that tell which source registers an opcode actually reads.
package otter_pkg;

   typedef enum logic [6:0] {
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111,
      OP_BRANCH = 7'b1100011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_IMM    = 7'b0010011,
      OP_OP     = 7'b0110011,
      OP_SYSTEM = 7'b1110011
   } opcode_t;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_FLUSH    = 2'd2,
      ST_INTR     = 2'd3
   } hz_state_t;

   localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

   // Upper-immediate and JAL encodings carry immediate bits where rs1 would sit.
   function automatic logic uses_rs1(input logic [6:0] op);
      case (op)
         OP_LUI, OP_AUIPC, OP_JAL: uses_rs1 = 1'b0;
         default:                  uses_rs1 = 1'b1;
      endcase
   endfunction

   function automatic logic uses_rs2(input logic [6:0] op);
      case (op)
         OP_OP, OP_STORE, OP_BRANCH: uses_rs2 = 1'b1;
         default:                    uses_rs2 = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in execute whose destination is read by the instruction in decode.
module load_use_detect
   import otter_pkg::*;
(
   input  logic [31:0] DEC_IR,
   input  logic [31:0] EXE_IR,
   output logic        LOAD_USE
);

   logic [4:0] exe_rd_s;
   logic [4:0] dec_rs1_s;
   logic [4:0] dec_rs2_s;
   logic       rs1_hit_s;
   logic       rs2_hit_s;
   logic       unused_bits_s;

   assign exe_rd_s  = EXE_IR[11:7];
   assign dec_rs1_s = DEC_IR[19:15];
   assign dec_rs2_s = DEC_IR[24:20];

   assign rs1_hit_s = uses_rs1(DEC_IR[6:0]) && (dec_rs1_s == exe_rd_s);
   assign rs2_hit_s = uses_rs2(DEC_IR[6:0]) && (dec_rs2_s == exe_rd_s);

   // x0 never carries a value, so a load into x0 creates no dependency.
   assign LOAD_USE = (EXE_IR[6:0] == OP_LOAD) && (exe_rd_s != 5'd0) &&
                     (rs1_hit_s || rs2_hit_s);

   assign unused_bits_s = ^{DEC_IR[31:25], DEC_IR[14:7], EXE_IR[31:12]};

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: memory stalls, load-use bubbles,
// two-cycle fetch squash on control transfer, and interrupt entry.
module pipeline_hazard_ctrl
   import otter_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] DEC_IR,
   input  logic [31:0] EXE_IR,
   input  logic        BR_TAKEN,
   input  logic        MEM_REQ,
   input  logic        MEM_READY,
   input  logic        INTR,
   input  logic        INT_EN,
   output logic        PC_WE,
   output logic        IF_DEC_WE,
   output logic        DEC_EXE_WE,
   output logic        EXE_MEM_WE,
   output logic        MEM_WB_WE,
   output logic        IF_DEC_FLUSH,
   output logic        DEC_EXE_FLUSH,
   output logic        MEM_WB_FLUSH,
   output logic        INT_TAKEN,
   output logic [1:0]  STATE,
   output logic [15:0] STALL_CNT
);

   hz_state_t   state_r;
   hz_state_t   next_state_s;
   logic        ret_flush_r;
   logic        ret_flush_next_s;
   logic [15:0] stall_cnt_r;
   logic        load_use_s;
   logic        mem_stall_s;
   logic [4:0]  we_s;     // {PC, IF/DEC, DEC/EXE, EXE/MEM, MEM/WB}
   logic [2:0]  flush_s;  // {IF/DEC, DEC/EXE, MEM/WB}
   logic        int_taken_s;

   load_use_detect u_load_use (
      .DEC_IR   (DEC_IR),
      .EXE_IR   (EXE_IR),
      .LOAD_USE (load_use_s)
   );

   assign mem_stall_s = MEM_REQ && !MEM_READY;

   // Next-state and stage-control decode.
   always_comb begin
      next_state_s     = state_r;
      ret_flush_next_s = ret_flush_r;
      we_s             = 5'b11111;
      flush_s          = 3'b000;
      int_taken_s      = 1'b0;
      if (!rst_n) begin
         we_s         = 5'b00000;
         flush_s      = 3'b111;
         next_state_s = ST_RUN;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (mem_stall_s) begin
                  we_s             = 5'b00000;
                  flush_s          = 3'b001;
                  ret_flush_next_s = 1'b0;
                  next_state_s     = ST_MEM_WAIT;
               end else if (load_use_s) begin
                  we_s    = 5'b00111;
                  flush_s = 3'b010;
               end else if (BR_TAKEN) begin
                  flush_s      = 3'b100;
                  next_state_s = ST_FLUSH;
               end else if (INTR && INT_EN) begin
                  next_state_s = ST_INTR;
               end else begin
                  next_state_s = ST_RUN;
               end
            end
            ST_MEM_WAIT: begin
               if (!MEM_READY) begin
                  we_s    = 5'b00000;
                  flush_s = 3'b001;
               end else begin
                  // A stall that interrupted a squash resumes the squash afterwards.
                  next_state_s     = ret_flush_r ? ST_FLUSH : ST_RUN;
                  ret_flush_next_s = 1'b0;
               end
            end
            ST_FLUSH: begin
               if (mem_stall_s) begin
                  we_s             = 5'b00000;
                  flush_s          = 3'b101;
                  ret_flush_next_s = 1'b1;
                  next_state_s     = ST_MEM_WAIT;
               end else begin
                  flush_s      = 3'b100;
                  next_state_s = ST_RUN;
               end
            end
            ST_INTR: begin
               int_taken_s  = 1'b1;
               flush_s      = 3'b110;
               next_state_s = ST_FLUSH;
            end
            default: begin
               next_state_s     = ST_RUN;
               ret_flush_next_s = 1'b0;
            end
         endcase
      end
   end

   assign {PC_WE, IF_DEC_WE, DEC_EXE_WE, EXE_MEM_WE, MEM_WB_WE} = we_s;
   assign {IF_DEC_FLUSH, DEC_EXE_FLUSH, MEM_WB_FLUSH}           = flush_s;
   assign INT_TAKEN = int_taken_s;
   assign STATE     = state_r;
   assign STALL_CNT = stall_cnt_r;

   // FSM state and squash-resume flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_RUN;
         ret_flush_r <= 1'b0;
      end else begin
         state_r     <= next_state_s;
         ret_flush_r <= ret_flush_next_s;
      end
   end

   // Saturating count of cycles with the PC held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_r <= 16'd0;
      end else if (!we_s[4] && (stall_cnt_r != STALL_CNT_MAX)) begin
         stall_cnt_r <= stall_cnt_r + 16'd1;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: each cycle's expected controls are queued
// when inputs are driven and compared once the outputs settle.
module tb_pipeline_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] DEC_IR = 32'h00000013;
   logic [31:0] EXE_IR = 32'h00000013;
   logic        BR_TAKEN = 1'b0, MEM_REQ = 1'b0, MEM_READY = 1'b1, INTR = 1'b0, INT_EN = 1'b0;
   logic        PC_WE, IF_DEC_WE, DEC_EXE_WE, EXE_MEM_WE, MEM_WB_WE;
   logic        IF_DEC_FLUSH, DEC_EXE_FLUSH, MEM_WB_FLUSH, INT_TAKEN;
   logic [1:0]  STATE;
   logic [15:0] STALL_CNT;

   int          tests_run = 0;
   int          tests_failed = 0;
   logic [15:0] exp_cnt = 16'd0;
   logic [26:0] exp_q[$];

   localparam logic [31:0] NOP        = 32'h00000013;
   localparam logic [31:0] LW_X5      = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
   localparam logic [31:0] LW_X0      = {12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011};
   localparam logic [31:0] ADD_6_5_2  = {7'd0, 5'd2, 5'd5, 3'b000, 5'd6, 7'b0110011};
   localparam logic [31:0] ADD_6_2_5  = {7'd0, 5'd5, 5'd2, 3'b000, 5'd6, 7'b0110011};
   localparam logic [31:0] ADD_6_0_0  = {7'd0, 5'd0, 5'd0, 3'b000, 5'd6, 7'b0110011};
   localparam logic [31:0] LUI_RS1_5  = {12'h000, 5'd5, 3'b000, 5'd6, 7'b0110111};
   localparam logic [31:0] ADDI_RS2_5 = {12'd5, 5'd1, 3'b000, 5'd6, 7'b0010011};

   localparam logic [4:0] WE_ALL = 5'b11111, WE_NONE = 5'b00000, WE_LU = 5'b00111;
   localparam logic [2:0] FL_NONE = 3'b000, FL_IF = 3'b100, FL_LU = 3'b010;
   localparam logic [2:0] FL_MEM = 3'b001, FL_INT = 3'b110, FL_RST = 3'b111;
   localparam logic [1:0] S_RUN = 2'd0, S_MW = 2'd1, S_FL = 2'd2, S_IN = 2'd3;

   pipeline_hazard_ctrl dut (
      .clk(clk), .rst_n(rst_n), .DEC_IR(DEC_IR), .EXE_IR(EXE_IR),
      .BR_TAKEN(BR_TAKEN), .MEM_REQ(MEM_REQ), .MEM_READY(MEM_READY),
      .INTR(INTR), .INT_EN(INT_EN),
      .PC_WE(PC_WE), .IF_DEC_WE(IF_DEC_WE), .DEC_EXE_WE(DEC_EXE_WE),
      .EXE_MEM_WE(EXE_MEM_WE), .MEM_WB_WE(MEM_WB_WE),
      .IF_DEC_FLUSH(IF_DEC_FLUSH), .DEC_EXE_FLUSH(DEC_EXE_FLUSH),
      .MEM_WB_FLUSH(MEM_WB_FLUSH), .INT_TAKEN(INT_TAKEN),
      .STATE(STATE), .STALL_CNT(STALL_CNT)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [26:0] got, input logic [26:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got we=%b fl=%b it=%b st=%0d cnt=%h, expected we=%b fl=%b it=%b st=%0d cnt=%h",
                  tag, got[26:22], got[21:19], got[18], got[17:16], got[15:0],
                  exp[26:22], exp[21:19], exp[18], exp[17:16], exp[15:0]);
      end
   endtask

   // Drive one cycle at the falling edge, queue expectations, compare mid-cycle.
   task automatic cyc(input string tag, input logic [31:0] dec, input logic [31:0] exe,
                      input logic br, input logic mreq, input logic mrdy,
                      input logic intr, input logic inten,
                      input logic [4:0] we, input logic [2:0] fl, input logic it,
                      input logic [1:0] st);
      logic [26:0] exp_v;
      DEC_IR = dec; EXE_IR = exe; BR_TAKEN = br; MEM_REQ = mreq;
      MEM_READY = mrdy; INTR = intr; INT_EN = inten;
      if (!rst_n) exp_cnt = 16'd0;
      exp_q.push_back({we, fl, it, st, exp_cnt});
      #2;
      exp_v = exp_q.pop_front();
      check_eq(tag, {PC_WE, IF_DEC_WE, DEC_EXE_WE, EXE_MEM_WE, MEM_WB_WE,
                     IF_DEC_FLUSH, DEC_EXE_FLUSH, MEM_WB_FLUSH, INT_TAKEN,
                     STATE, STALL_CNT}, exp_v);
      if (rst_n && !we[4] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      cyc("reset_idle", NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, WE_NONE, FL_RST, 1'b0, S_RUN);
      cyc("reset_br",   NOP, NOP, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, WE_NONE, FL_RST, 1'b0, S_RUN);
      rst_n = 1'b1;
      cyc("first_run",  NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, WE_ALL, FL_NONE, 1'b0, S_RUN);

      cyc("lu_rs1",      ADD_6_5_2, LW_X5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, WE_LU, FL_LU, 1'b0, S_RUN);
      cyc("lu_release",  ADD_6_5_2, NOP,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, WE_ALL, FL_NONE, 1'b0, S_RUN);
      cyc("lu_rs2_br",   ADD_6_2_5, LW_X5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, WE_LU, FL_LU, 1'b0, S_RUN);
      cyc("lu_br_gone",  ADD_6_2_5, NOP,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, WE_ALL, FL_NONE, 1'b0, S_RUN);
      cyc("lw_x0",       ADD_6_0_0, LW_X0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, WE_ALL, FL_NONE, 1'b0, S_RUN);
      cyc("lui_no_rs1",  LUI_RS1_5, LW_X5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, WE_ALL, FL_NONE, 1'b0, S_RUN);
      cyc("addi_no_rs2", ADDI_RS2_5, LW_X5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, WE_ALL, FL_NONE, 1'b0, S_RUN);

      cyc("br_cyc1", NOP, NOP, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, WE_ALL, FL_IF, 1'b0, S_RUN);
      cyc("br_cyc2", NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, WE_ALL, FL_IF, 1'b0, S_FL);
      cyc("br_done", NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, WE_ALL, FL_NONE, 1'b0, S_RUN);

      cyc("mem_w1",  ADD_6_5_2, LW_X5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, WE_NONE, FL_MEM, 1'b0, S_RUN);
      cyc("mem_w2",  NOP, NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, WE_NONE, FL_MEM, 1'b0, S_MW);
      cyc("mem_w3",  NOP, NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, WE_NONE, FL_MEM, 1'b0, S_MW);
      cyc("mem_rdy", NOP, NOP, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, WE_ALL, FL_NONE, 1'b0, S_MW);
      cyc("mem_run", NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, WE_ALL, FL_NONE, 1'b0, S_RUN);

      cyc("int_req",   NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, WE_ALL, FL_NONE, 1'b0, S_RUN);
      cyc("int_take",  NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, WE_ALL, FL_INT, 1'b1, S_IN);
      cyc("int_flush", NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, WE_ALL, FL_IF, 1'b0, S_FL);
      cyc("int_run",   NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, WE_ALL, FL_NONE, 1'b0, S_RUN);
      cyc("int_dis1",  NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, WE_ALL, FL_NONE, 1'b0, S_RUN);
      cyc("int_dis2",  NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, WE_ALL, FL_NONE, 1'b0, S_RUN);
      cyc("br_over_int", NOP, NOP, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, WE_ALL, FL_IF, 1'b0, S_RUN);
      cyc("br_int_fl",   NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, WE_ALL, FL_IF, 1'b0, S_FL);
      cyc("br_int_run",  NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, WE_ALL, FL_NONE, 1'b0, S_RUN);

      cyc("fm_br",    NOP, NOP, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, WE_ALL, FL_IF, 1'b0, S_RUN);
      cyc("fm_stall", NOP, NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, WE_NONE, 3'b101, 1'b0, S_FL);
      cyc("fm_wait",  NOP, NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, WE_NONE, FL_MEM, 1'b0, S_MW);
      cyc("fm_rdy",   NOP, NOP, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, WE_ALL, FL_NONE, 1'b0, S_MW);
      cyc("fm_flush", NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, WE_ALL, FL_IF, 1'b0, S_FL);
      cyc("fm_run",   NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, WE_ALL, FL_NONE, 1'b0, S_RUN);

      force dut.stall_cnt_r = 16'hFFFD;
      #1;
      release dut.stall_cnt_r;
      exp_cnt = 16'hFFFD;
      cyc("sat_fffd", NOP, NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, WE_NONE, FL_MEM, 1'b0, S_RUN);
      cyc("sat_fffe", NOP, NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, WE_NONE, FL_MEM, 1'b0, S_MW);
      cyc("sat_ffff", NOP, NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, WE_NONE, FL_MEM, 1'b0, S_MW);
      cyc("sat_hold", NOP, NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, WE_NONE, FL_MEM, 1'b0, S_MW);
      rst_n = 1'b0;
      cyc("rst_mid_wait", NOP, NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, WE_NONE, FL_RST, 1'b0, S_RUN);
      rst_n = 1'b1;
      cyc("post_rst_run", NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, WE_ALL, FL_NONE, 1'b0, S_RUN);
      cyc("post_rst_cnt", NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, WE_ALL, FL_NONE, 1'b0, S_RUN);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
